// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a byte stream from a host link (a 1-byte word-count
//               header, then 4 little-endian bytes per word). It writes each
//               assembled word into instruction memory and holds the CPU in
//               stall while the load runs.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int N  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [N-1:0]  wr_data,
    output logic          cpu_hold,
    output logic          done,
    output logic          err
);

    // Largest legal word count; any header above this is rejected.
    localparam logic [7:0] c_depth = 8'(1 << AW);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_BYTES = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_in_ready;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [N-1:0]  r_wr_data;
    logic          r_cpu_hold;
    logic          r_done;
    logic          r_err;
    logic [AW:0]   r_cnt;     // word count C from the header
    logic [AW-1:0] r_widx;    // word index W
    logic [1:0]    r_bidx;    // byte index B within the current word
    logic [23:0]   r_asm;     // lower three bytes; the fourth goes straight to wr_data

    logic          w_xfer;
    logic          w_last;

    assign w_xfer = in_valid & r_in_ready;
    // Current word is the final one when W + 1 equals C.
    assign w_last = (({1'b0, r_widx} + (AW+1)'(1)) == r_cnt);

    // Loader state machine; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_widx     <= '0;
            r_bidx     <= '0;
            r_asm      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_in_ready <= 1'b0;
                    r_cpu_hold <= 1'b0;
                    if (start) begin
                        r_state    <= S_HDR;
                        r_in_ready <= 1'b1;
                        r_cpu_hold <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_cnt  <= in_data[AW:0];
                        r_widx <= '0;
                        r_bidx <= '0;
                        if (in_data == 8'd0) begin
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else if (in_data > c_depth) begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_BYTES;
                        end
                    end
                end
                S_BYTES: begin
                    if (w_xfer) begin
                        r_bidx <= r_bidx + 2'd1;
                        case (r_bidx)
                            2'd0: r_asm[7:0]   <= in_data;
                            2'd1: r_asm[15:8]  <= in_data;
                            2'd2: r_asm[23:16] <= in_data;
                            default: begin
                                r_state    <= S_WRITE;
                                r_in_ready <= 1'b0;
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= r_widx;
                                r_wr_data  <= {in_data, r_asm};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    r_wr_en <= 1'b0;
                    r_bidx  <= '0;
                    if (w_last) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else begin
                        r_widx     <= r_widx + AW'(1);
                        r_state    <= S_BYTES;
                        r_in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader. The driver pushes expected
//               writes/done/err events derived from the byte payload; a
//               monitor pops and compares them whenever the DUT emits one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader #(.N(32), .AW(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    localparam int K_WR   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [5:0]  addr;
        logic [31:0] data;
        int          offs;   // cycles after the header transfer, -1 = unchecked
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pl[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         hdr_cyc = 0;
    int         last_xfer = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge counter for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == K_WR && kind == K_WR) begin
                chk("wr_addr", {26'd0, wr_addr}, {26'd0, e.addr});
                chk("wr_data", wr_data, e.data);
            end
            if (e.offs >= 0)
                chk("latency", cyc - hdr_cyc, e.offs);
        end
    endtask

    // Monitor: compare every DUT event with the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (wr_en) begin
                pop_check(K_WR);
                chk("wr_ready_low", {31'd0, in_ready}, 32'd0);
                chk("wr_hold", {31'd0, cpu_hold}, 32'd1);
            end
            if (done) begin
                pop_check(K_DONE);
                chk("done_hold", {31'd0, cpu_hold}, 32'd0);
            end
            if (err) begin
                pop_check(K_ERR);
                chk("err_hold", {31'd0, cpu_hold}, 32'd0);
                chk("err_ready", {31'd0, in_ready}, 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit mst);
        int t;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        start    = mst ? 1'($urandom_range(0, 1)) : 1'b0;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("ready_timeout", 32'(t), 32'd0);
        end else begin
            last_xfer = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((cpu_hold || done || err || wr_en) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", {31'd0, t >= 100}, 32'd0);
        chk("idle_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic fill_random(input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
    endtask

    // One load session using the payload in pl; only nsend data bytes are sent.
    task automatic run_session(input int hdr, input int nsend, input bit gaps, input bit mst);
        ev_t e;
        int  nb;
        int  full;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        chk("ready_in_hdr", {31'd0, in_ready}, 32'd1);
        nb = (nsend < 4 * hdr) ? nsend : 4 * hdr;
        if (hdr > 64) begin
            e.kind = K_ERR; e.addr = '0; e.data = '0; e.offs = 0;
            exp_q.push_back(e);
        end else begin
            full = nb / 4;
            for (int w = 0; w < full; w++) begin
                e.kind = K_WR;
                e.addr = 6'(w);
                e.data = {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]};
                e.offs = -1;
                exp_q.push_back(e);
            end
            if (nb == 4 * hdr) begin
                e.kind = K_DONE; e.addr = '0; e.data = '0;
                e.offs = gaps ? -1 : 5 * hdr;
                exp_q.push_back(e);
            end
        end
        send_byte(8'(hdr), 1'b0, 1'b0);
        hdr_cyc = last_xfer;
        if (hdr <= 64)
            for (int i = 0; i < nb; i++) send_byte(pl[i], gaps, mst);
        if (hdr > 64 || nb == 4 * hdr)
            wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
        chk({tag, "_wr_addr"},  {26'd0, wr_addr},  32'd0);
        chk({tag, "_wr_data"},  wr_data,           32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_err"},      {31'd0, err},      32'd0);
    endtask

    initial begin
        int h;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        reset = 1'b1;

        // Directed single word, start issued on the first edge after reset.
        pl.delete();
        pl.push_back(8'h13); pl.push_back(8'h05); pl.push_back(8'h50); pl.push_back(8'h00);
        run_session(1, 4, 1'b0, 1'b0);

        // Full 64-word load, gap-free.
        fill_random(256);
        run_session(64, 256, 1'b0, 1'b0);

        // Oversized header, then empty header.
        pl.delete();
        run_session(65, 0, 1'b0, 1'b0);
        run_session(0, 0, 1'b0, 1'b0);

        // Two words with random valid gaps and stray start pulses.
        fill_random(8);
        run_session(2, 8, 1'b1, 1'b1);

        // Reset after two bytes of word 1.
        fill_random(8);
        run_session(2, 6, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b1;
        fill_random(4);
        run_session(1, 4, 1'b0, 1'b0);

        // Random sessions.
        for (int s = 0; s < 8; s++) begin
            if ($urandom_range(0, 3) == 0) h = $urandom_range(65, 255);
            else                           h = $urandom_range(1, 5);
            fill_random((h > 64) ? 0 : 4 * h);
            run_session(h, (h > 64) ? 0 : 4 * h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
